queue_status_ctrl: RTL and testbench
====================================

// Module: queue_status_ctrl
// PURPOSE
// - Occupancy/flow-control companion to the multi-lane queue tag manager. The tag manager turns fires into
//   slot tags; this block produces the per-lane readiness masks those fires must obey.
// - Tracks queue usage and drives per-lane enq_rdy (space) and deq_vld (data) masks.
// - Drives full/empty/almost-full flags, a sticky overflow/underflow error, and a high-water mark.
// - Sits beside each queue instance. Producers gate enq_fire with enq_rdy; consumers gate deq_fire with deq_vld.
// PARAMETERS
// - Depth        8  queue entries (any value >= 2, power of two not required)
// - EnqWidth     2  enqueue lanes per cycle (<= Depth)
// - DeqWidth     2  dequeue lanes per cycle (<= Depth)
// - EnqCollapse  0  1: lanes with eval=0 consume no slot; 0: lane i needs i+1 slots
// - DeqCollapse  0  same semantics on the dequeue side
// - InitFull     0  1: reset/flush usage = Depth (free-list use); 0: usage = 0
// - AfThresh     Depth-1  almost_full_o asserts when usage >= AfThresh
// - localparam CntWidth = $clog2(Depth+1)
// PORTS
// - clk            in   1               clock, all state on posedge
// - rstn           in   1               asynchronous active-low reset
// - enq_eval_i     in   EnqWidth        lane holds a candidate for enqueue
// - enq_fire_i     in   EnqWidth        lane enqueues this cycle; must be a subset of enq_eval_i & enq_rdy_o
// - enq_rdy_o      out  EnqWidth        lane may fire this cycle
// - deq_eval_i     in   DeqWidth        lane requests a dequeue
// - deq_fire_i     in   DeqWidth        lane dequeues this cycle; must be a subset of deq_eval_i & deq_vld_o
// - deq_vld_o      out  DeqWidth        lane has an entry to take
// - flush_i        in   1               synchronous clear of usage (has priority over fires)
// - usage_o        out  CntWidth        current occupancy (registered)
// - full_o / empty_o / almost_full_o  out 1 each   registered flags
// - hwm_o          out  CntWidth        highest usage since reset/flush
// - err_o          out  1               sticky: a fire exceeded its mask; cleared only by reset
// BEHAVIOUR
// - Reset values:
//   - usage_q = InitFull ? Depth : 0; hwm_q = usage_q reset value; err_q = 0.
//   - full_o = InitFull; empty_o = ~InitFull; almost_full_o = (reset usage >= AfThresh).
// - Masks are combinational from registered usage and the eval inputs only. No fire input reaches them,
//   so there is no same-cycle bypass.
//   - Space avail = Depth - usage_q.
//   - need_enq[i] = EnqCollapse ? popcount(enq_eval_i[i:0]) : i+1.
//   - enq_rdy_o[i] = enq_eval_i[i] & (need_enq[i] <= avail).
//   - deq_vld_o[i] = deq_eval_i[i] & (need_deq[i] <= usage_q), with need_deq defined the same way.
// - Fire rules: any valid fire pattern is accepted.
//   - Non-collapse mode: fires must be a lane prefix.
//   - Collapse mode: holes between fires are allowed when the hole lanes have eval=0.
// - Update: usage_d = usage_q + popcount(enq_fire_i) - popcount(deq_fire_i).
//   - Compute at CntWidth+1 bits; the result never exceeds Depth nor drops below 0 when the fire rules hold.
// - Simultaneous enq and deq: both apply in the same cycle. A dequeue does not free space for a
//   same-cycle enqueue. Full with enq+deq both firing is not possible, because enq_rdy=0 when full.
// - flush_i: usage_d = InitFull ? Depth : 0, and hwm resets to the same value. Fires in the flush cycle
//   are ignored. err_q is unaffected.
// - Flags are registered from usage_d:
//   - full = (usage_d == Depth); empty = (usage_d == 0); almost_full = (usage_d >= AfThresh).
// - hwm_d = max(hwm_q, usage_d).
// - Error: err_d = err_q | (|(enq_fire_i & ~enq_rdy_o)) | (|(deq_fire_i & ~deq_vld_o)).
//   - On an error, usage_d saturates to the range [0, Depth]; no wrap.
//   - Simulation-only assertions fire $fatal on the same condition.
// - Reset asserted mid-operation: all state returns to its reset values immediately (asynchronous reset).
// STRUCTURE
// - Add to the shared queue package:
//   - prefix-popcount function (lane index, eval vector).
//   - function computing the reset usage value (InitFull, Depth).
// - Reuse the existing CountOne sub-module for the enq and deq fire counts.
// - Reuse DFFRE for usage/hwm/err/flags with the asynchronous reset; no new sub-module.
// TESTING
// - Config for all scenarios: Depth=8, EnqWidth=DeqWidth=2, non-collapse, InitFull=0.
// - Fill: 4 cycles of enq_fire=2'b11 -> usage_o 2,4,6,8. After the 4th cycle: full_o=1, enq_rdy_o=2'b00,
//   almost_full_o has been set since usage reached 7 or more, hwm_o=8.
// - Partial space: usage=7, enq_eval=2'b11 -> enq_rdy_o=2'b01. Fire 2'b01 -> usage=8, err_o=0.
// - Simultaneous: usage=1, enq_fire=2'b11, deq_eval=2'b11 -> deq_vld_o=2'b01. deq_fire=2'b01 -> usage=2.
// - Collapse (EnqCollapse=1): usage=7, enq_eval=2'b10 -> enq_rdy_o=2'b10. Fire lane1 -> usage=8.
// - Flush with fires: usage=5, flush_i=1 with enq_fire=2'b11 -> usage=0, empty_o=1, hwm_o=0.
//   With InitFull=1 the same stimulus -> usage=8, full_o=1.
// - Violation: usage=8, force enq_fire=2'b01 -> err_o=1 (sticky), usage stays 8, assertion triggers.
//   Reset mid-run -> err_o=0, usage=0.

Source files
------------

// File: rtl/queue_status_ctrl_pkg.sv
// Shared queue helpers: lane popcounts and the reset/flush occupancy value
// used by the queue status controller.
package queue_status_ctrl_pkg;

   localparam int unsigned MaxLanes = 32;

   function automatic int unsigned popcount(input logic [MaxLanes-1:0] vec);
      int unsigned n;
      n = 0;
      for (int unsigned k = 0; k < MaxLanes; k++) begin
         n += {31'd0, vec[k]};
      end
      return n;
   endfunction

   // Number of set bits in eval[lane:0]: the slots lane needs when empty lanes collapse.
   function automatic int unsigned prefix_pop(input int unsigned lane,
                                              input logic [MaxLanes-1:0] eval);
      int unsigned n;
      n = 0;
      for (int unsigned k = 0; k < MaxLanes; k++) begin
         if (k <= lane) n += {31'd0, eval[k]};
      end
      return n;
   endfunction

   function automatic int unsigned reset_usage(input bit init_full, input int unsigned depth);
      return init_full ? depth : 0;
   endfunction

endpackage

// File: rtl/queue_status_ctrl_if.sv
// Per-lane enqueue/dequeue handshake between queue users and the status controller.
interface queue_status_ctrl_if #(
   parameter int EnqWidth = 2,
   parameter int DeqWidth = 2
);
   logic [EnqWidth-1:0] enq_eval;
   logic [EnqWidth-1:0] enq_fire;
   logic [EnqWidth-1:0] enq_rdy;
   logic [DeqWidth-1:0] deq_eval;
   logic [DeqWidth-1:0] deq_fire;
   logic [DeqWidth-1:0] deq_vld;

   modport master (
      output enq_eval, enq_fire, deq_eval, deq_fire,
      input  enq_rdy, deq_vld
   );

   modport slave (
      input  enq_eval, enq_fire, deq_eval, deq_fire,
      output enq_rdy, deq_vld
   );
endinterface

// File: rtl/queue_status_ctrl.sv
// Queue occupancy tracker: per-lane space/data masks from registered usage, registered
// full/empty/almost-full flags, high-water mark and a sticky fire-outside-mask error.
module queue_status_ctrl
   import queue_status_ctrl_pkg::*;
#(
   parameter int Depth       = 8,
   parameter int EnqWidth    = 2,
   parameter int DeqWidth    = 2,
   parameter bit EnqCollapse = 1'b0,
   parameter bit DeqCollapse = 1'b0,
   parameter bit InitFull    = 1'b0,
   parameter int AfThresh    = Depth - 1,
   parameter bit FatalOnErr  = 1'b1,
   localparam int CntWidth   = $clog2(Depth + 1)
)(
   input  logic                clk,
   input  logic                rstn,
   queue_status_ctrl_if.slave  q_if,
   input  logic                flush_i,
   output logic [CntWidth-1:0] usage_o,
   output logic                full_o,
   output logic                empty_o,
   output logic                almost_full_o,
   output logic [CntWidth-1:0] hwm_o,
   output logic                err_o
);

   localparam logic [CntWidth-1:0] DepthC     = CntWidth'(Depth);
   localparam logic [CntWidth-1:0] ResetUsage = CntWidth'(reset_usage(InitFull, Depth));
   localparam int unsigned         AfU        = AfThresh;
   localparam bit                  AfRst      = (32'(ResetUsage) >= AfU);

   logic [CntWidth-1:0]        r_usage;
   logic [CntWidth-1:0]        r_hwm;
   logic                       r_full;
   logic                       r_empty;
   logic                       r_af;
   logic                       r_err;

   logic [CntWidth-1:0]        w_avail;
   logic [EnqWidth-1:0]        w_enq_rdy;
   logic [DeqWidth-1:0]        w_deq_vld;
   int unsigned                w_enq_cnt;
   int unsigned                w_deq_cnt;
   logic signed [CntWidth+1:0] w_sum;
   logic [CntWidth-1:0]        w_usage_d;
   logic [CntWidth-1:0]        w_hwm_d;
   logic                       w_viol;

   assign w_avail = DepthC - r_usage;

   // Masks look only at registered usage and eval, never at fires.
   always_comb begin
      w_enq_rdy = '0;
      for (int unsigned i = 0; i < EnqWidth; i++) begin
         w_enq_rdy[i] = q_if.enq_eval[i] &
            ((EnqCollapse ? prefix_pop(i, 32'(q_if.enq_eval)) : i + 1) <= 32'(w_avail));
      end
      w_deq_vld = '0;
      for (int unsigned i = 0; i < DeqWidth; i++) begin
         w_deq_vld[i] = q_if.deq_eval[i] &
            ((DeqCollapse ? prefix_pop(i, 32'(q_if.deq_eval)) : i + 1) <= 32'(r_usage));
      end
   end

   assign q_if.enq_rdy = w_enq_rdy;
   assign q_if.deq_vld = w_deq_vld;

   assign w_enq_cnt = popcount(32'(q_if.enq_fire));
   assign w_deq_cnt = popcount(32'(q_if.deq_fire));
   assign w_viol    = (|(q_if.enq_fire & ~w_enq_rdy)) | (|(q_if.deq_fire & ~w_deq_vld));

   // Signed sum with headroom so an illegal fire saturates instead of wrapping.
   always_comb begin
      w_sum = $signed({2'b00, r_usage})
            + $signed((CntWidth+2)'(w_enq_cnt))
            - $signed((CntWidth+2)'(w_deq_cnt));
      if (flush_i) begin
         w_usage_d = ResetUsage;
      end else if (w_sum[CntWidth+1]) begin
         w_usage_d = '0;
      end else if (w_sum > $signed({2'b00, DepthC})) begin
         w_usage_d = DepthC;
      end else begin
         w_usage_d = w_sum[CntWidth-1:0];
      end
      if (flush_i) begin
         w_hwm_d = ResetUsage;
      end else begin
         w_hwm_d = (w_usage_d > r_hwm) ? w_usage_d : r_hwm;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_usage <= ResetUsage;
         r_hwm   <= ResetUsage;
         r_full  <= InitFull;
         r_empty <= !InitFull;
         r_af    <= AfRst;
         r_err   <= 1'b0;
      end else begin
         r_usage <= w_usage_d;
         r_hwm   <= w_hwm_d;
         r_full  <= (w_usage_d == DepthC);
         r_empty <= (w_usage_d == '0);
         r_af    <= (32'(w_usage_d) >= AfU);
         r_err   <= r_err | w_viol;
      end
   end

   always @(posedge clk) begin
      if (FatalOnErr && rstn) begin
         assert (!w_viol)
            else $fatal(1, "queue_status_ctrl: fire outside enq_rdy/deq_vld mask");
      end
   end

   assign usage_o       = r_usage;
   assign hwm_o         = r_hwm;
   assign full_o        = r_full;
   assign empty_o       = r_empty;
   assign almost_full_o = r_af;
   assign err_o         = r_err;

endmodule

// File: tb/tb_queue_status_ctrl.sv
// Bench for queue_status_ctrl: default, enqueue-collapse and init-full instances,
// with a scoreboard of expected registered outputs for the default instance.
module tb_queue_status_ctrl;

   logic clk;
   logic rstn;
   logic a_flush, c_flush, f_flush;
   logic [3:0] a_usage, c_usage, f_usage, a_hwm, c_hwm, f_hwm;
   logic a_full, a_empty, a_af, a_err;
   logic c_full, c_empty, c_af, c_err;
   logic f_full, f_empty, f_af, f_err;

   int n_cmp;
   int n_bad;

   typedef struct {
      string       tag;
      int          kind;
      logic [31:0] exp;
   } ent_t;
   ent_t sb[$];

   int m_u, m_hwm;
   bit m_err;

   queue_status_ctrl_if #(.EnqWidth(2), .DeqWidth(2)) a_if ();
   queue_status_ctrl_if #(.EnqWidth(2), .DeqWidth(2)) c_if ();
   queue_status_ctrl_if #(.EnqWidth(2), .DeqWidth(2)) f_if ();

   queue_status_ctrl #(.FatalOnErr(1'b0)) u_a (
      .clk(clk), .rstn(rstn), .q_if(a_if.slave), .flush_i(a_flush),
      .usage_o(a_usage), .full_o(a_full), .empty_o(a_empty),
      .almost_full_o(a_af), .hwm_o(a_hwm), .err_o(a_err)
   );

   queue_status_ctrl #(.EnqCollapse(1'b1)) u_c (
      .clk(clk), .rstn(rstn), .q_if(c_if.slave), .flush_i(c_flush),
      .usage_o(c_usage), .full_o(c_full), .empty_o(c_empty),
      .almost_full_o(c_af), .hwm_o(c_hwm), .err_o(c_err)
   );

   queue_status_ctrl #(.InitFull(1'b1)) u_f (
      .clk(clk), .rstn(rstn), .q_if(f_if.slave), .flush_i(f_flush),
      .usage_o(f_usage), .full_o(f_full), .empty_o(f_empty),
      .almost_full_o(f_af), .hwm_o(f_hwm), .err_o(f_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
         else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
         end
   endtask

   function automatic logic [31:0] obs_of(input int kind);
      case (kind)
         0:       return 32'(a_usage);
         1:       return 32'(a_full);
         2:       return 32'(a_empty);
         3:       return 32'(a_af);
         4:       return 32'(a_hwm);
         default: return 32'(a_err);
      endcase
   endfunction

   task automatic push(input string tag, input int kind, input int exp);
      ent_t e;
      e.tag  = tag;
      e.kind = kind;
      e.exp  = 32'(exp);
      sb.push_back(e);
   endtask

   task automatic drain();
      ent_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk(e.tag, obs_of(e.kind), e.exp);
      end
   endtask

   // One cycle on the default instance, entered and left on a falling edge.
   task automatic cyc(input logic [1:0] ee, input logic [1:0] ef,
                      input logic [1:0] de, input logic [1:0] df, input logic fl);
      logic [1:0] rdy, vld;
      int pe, pd, s;
      a_if.enq_eval = ee;
      a_if.enq_fire = ef;
      a_if.deq_eval = de;
      a_if.deq_fire = df;
      a_flush       = fl;
      #1;
      for (int i = 0; i < 2; i++) begin
         rdy[i] = ee[i] && (i + 1 <= 8 - m_u);
         vld[i] = de[i] && (i + 1 <= m_u);
      end
      chk("enq_rdy", 32'(a_if.enq_rdy), 32'(rdy));
      chk("deq_vld", 32'(a_if.deq_vld), 32'(vld));
      if ((ef & ~rdy) != 2'b00 || (df & ~vld) != 2'b00) m_err = 1'b1;
      pe = int'(ef[0]) + int'(ef[1]);
      pd = int'(df[0]) + int'(df[1]);
      if (fl) begin
         m_u   = 0;
         m_hwm = 0;
      end else begin
         s   = m_u + pe - pd;
         m_u = (s < 0) ? 0 : ((s > 8) ? 8 : s);
         if (m_u > m_hwm) m_hwm = m_u;
      end
      push("usage", 0, m_u);
      push("full",  1, (m_u == 8) ? 1 : 0);
      push("empty", 2, (m_u == 0) ? 1 : 0);
      push("afull", 3, (m_u >= 7) ? 1 : 0);
      push("hwm",   4, m_hwm);
      push("err",   5, m_err ? 1 : 0);
      @(posedge clk);
      #1;
      drain();
      @(negedge clk);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      m_u = 0; m_hwm = 0; m_err = 1'b0;
      a_if.enq_eval = '0; a_if.enq_fire = '0; a_if.deq_eval = '0; a_if.deq_fire = '0;
      c_if.enq_eval = '0; c_if.enq_fire = '0; c_if.deq_eval = '0; c_if.deq_fire = '0;
      f_if.enq_eval = '0; f_if.enq_fire = '0; f_if.deq_eval = '0; f_if.deq_fire = '0;
      a_flush = 1'b0; c_flush = 1'b0; f_flush = 1'b0;
      rstn = 1'b1;
      #1 rstn = 1'b0;
      #7;
      chk("rst_usage", 32'(a_usage), 0);
      chk("rst_empty", 32'(a_empty), 1);
      chk("rst_full",  32'(a_full),  0);
      chk("rst_afull", 32'(a_af),    0);
      chk("rst_hwm",   32'(a_hwm),   0);
      chk("rst_err",   32'(a_err),   0);
      chk("if_rst_usage", 32'(f_usage), 8);
      chk("if_rst_full",  32'(f_full),  1);
      chk("if_rst_empty", 32'(f_empty), 0);
      chk("if_rst_afull", 32'(f_af),    1);
      chk("if_rst_hwm",   32'(f_hwm),   8);
      @(negedge clk);
      rstn = 1'b1;

      // Fill to full, then confirm no space is offered
      for (int k = 0; k < 4; k++) cyc(2'b11, 2'b11, 2'b00, 2'b00, 1'b0);
      cyc(2'b11, 2'b00, 2'b00, 2'b00, 1'b0);

      // Partial space at usage 7
      cyc(2'b00, 2'b00, 2'b01, 2'b01, 1'b0);
      cyc(2'b11, 2'b01, 2'b00, 2'b00, 1'b0);

      // Drain to 1, then simultaneous enq and deq
      for (int k = 0; k < 3; k++) cyc(2'b00, 2'b00, 2'b11, 2'b11, 1'b0);
      cyc(2'b00, 2'b00, 2'b01, 2'b01, 1'b0);
      cyc(2'b11, 2'b11, 2'b11, 2'b01, 1'b0);

      // Flush with fires at usage 5
      cyc(2'b11, 2'b11, 2'b00, 2'b00, 1'b0);
      cyc(2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
      cyc(2'b11, 2'b11, 2'b00, 2'b00, 1'b1);

      // Overfill violation while full; error stays set
      for (int k = 0; k < 4; k++) cyc(2'b11, 2'b11, 2'b00, 2'b00, 1'b0);
      cyc(2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
      cyc(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

      // Asynchronous reset in the middle of a cycle
      a_if.enq_eval = '0; a_if.enq_fire = '0;
      #2 rstn = 1'b0;
      #1;
      chk("mid_rst_err",   32'(a_err),   0);
      chk("mid_rst_usage", 32'(a_usage), 0);
      chk("mid_rst_hwm",   32'(a_hwm),   0);
      chk("mid_rst_empty", 32'(a_empty), 1);
      m_u = 0; m_hwm = 0; m_err = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      cyc(2'b11, 2'b11, 2'b00, 2'b00, 1'b0);

      // Collapse instance: bring to 7, then lane 1 alone needs one slot
      for (int k = 0; k < 4; k++) begin
         c_if.enq_eval = (k < 3) ? 2'b11 : 2'b01;
         c_if.enq_fire = (k < 3) ? 2'b11 : 2'b01;
         @(posedge clk);
         @(negedge clk);
      end
      c_if.enq_eval = 2'b10;
      c_if.enq_fire = 2'b00;
      #1;
      chk("col_usage7", 32'(c_usage), 7);
      chk("col_rdy", 32'(c_if.enq_rdy), 32'(2'b10));
      c_if.enq_fire = 2'b10;
      @(posedge clk);
      #1;
      chk("col_usage8", 32'(c_usage), 8);
      chk("col_full",   32'(c_full),  1);
      chk("col_err",    32'(c_err),   0);
      @(negedge clk);
      c_if.enq_eval = 2'b00;
      c_if.enq_fire = 2'b00;

      // Init-full instance: drain to 5, then flush with enqueue fires
      f_if.deq_eval = 2'b11;
      f_if.deq_fire = 2'b11;
      @(posedge clk);
      @(negedge clk);
      f_if.deq_fire = 2'b01;
      @(posedge clk);
      #1;
      chk("if_usage5", 32'(f_usage), 5);
      @(negedge clk);
      f_if.deq_eval = 2'b00;
      f_if.deq_fire = 2'b00;
      f_if.enq_eval = 2'b11;
      f_if.enq_fire = 2'b11;
      f_flush = 1'b1;
      @(posedge clk);
      #1;
      chk("if_flush_usage", 32'(f_usage), 8);
      chk("if_flush_full",  32'(f_full),  1);
      chk("if_flush_hwm",   32'(f_hwm),   8);
      chk("if_flush_empty", 32'(f_empty), 0);
      @(negedge clk);
      f_flush = 1'b0;
      f_if.enq_eval = 2'b00;
      f_if.enq_fire = 2'b00;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
